button_cmd_scheduler: RTL and testbench
=======================================

# button_cmd_scheduler

Edit-mode controller sitting between the five push-button conditioners (single-cycle release ticks) and the time-register write port. Latches button ticks so none are lost, arbitrates them by fixed priority, runs the edit state machine (enter/exit edit, field selection, increment/decrement), and issues one command at a time over a valid/ready handshake. Abandons an edit session after a configurable inactivity timeout.

## Interface
- TIMEOUT_CYCLES, 500_000_000, EDIT-state inactivity limit in clkr cycles (≥2)
- CNT_W, 32, timeout counter width; must hold TIMEOUT_CYCLES-1
- clkr  in  1  system clock; all logic on rising edge
- resetr  in  1  synchronous, active-high reset
- tick_enter, tick_up, tick_down, tick_left, tick_right  in  1 each  one-cycle pulses from the button conditioners
- cmd_ready  in  1  write port accepts current command
- cmd_valid  out  1  command pending on cmd_op/cmd_field
- cmd_op  out  1  0 = INC, 1 = DEC
- cmd_field  out  2  0 = SEC, 1 = MIN, 2 = HR (3 never driven)
- edit_mode  out  1  high in EDIT and ISSUE
- field_sel  out  2  field currently selected (cursor for display)
- commit_pulse  out  1  one cycle, edit finished by enter
- abort_pulse  out  1  one cycle, edit dropped by timeout

## Operation
- Pending register (5 bits, one per button): tick sets bit; bit cleared when serviced or discarded. Same-cycle set and clear of one bit: set wins (stays pending).
- Priority among pending bits: enter > up > down > left > right; only the winner is serviced per cycle, others remain pending.
- States: IDLE, EDIT, ISSUE.
- IDLE: pending enter → EDIT, field_sel ← SEC, timeout counter ← 0. All other pending bits discarded (cleared) in IDLE.
- EDIT: enter → IDLE with commit_pulse; up → ISSUE (op INC); down → ISSUE (op DEC); left → field_sel + 1 wrapping HR→SEC; right → field_sel − 1 wrapping SEC→HR. Any serviced button clears the counter.
- EDIT with no pending bit: counter increments; when counter = TIMEOUT_CYCLES-1 → IDLE with abort_pulse, pending cleared.
- ISSUE: cmd_valid = 1, cmd_field = field_sel, cmd_op held stable; no button serviced (ticks still latch); counter held. cmd_ready high → EDIT next edge, counter ← 0. cmd_ready high while cmd_valid low is ignored.
- field_sel changes only in EDIT; never 3.

## Timing
- Reset values: cmd_valid 0, cmd_op 0, cmd_field 0, edit_mode 0, field_sel 0, commit_pulse 0, abort_pulse 0, pending 0, counter 0, state IDLE.
- Tick sampled at edge E0 → pending at E0 → FSM acts at E1 → outputs (cmd_valid, field_sel, pulses, edit_mode) visible after E1: 2-edge latency, all outputs registered.
- Handshake: transfer on edge with cmd_valid & cmd_ready; cmd_valid drops after that edge; minimum one cycle between commands (returns via EDIT).
- Back-to-back ticks of the same button while its bit is set merge into one press.
- resetr mid-ISSUE: cmd_valid low after the reset edge, no pulse emitted, pending cleared.
- Timeout and new tick on the same edge: tick latched, timeout still taken (IDLE), latched non-enter bit discarded next cycle.

## Structure
- Shared package: op encoding (INC/DEC), field encoding (SEC/MIN/HR), state enum, button index constants.
- Sub-module button_prio_arbiter: 5-bit pending in, one-hot grant out, fixed priority as above; top holds pending register, FSM, counter.

## Test plan
- Reset, then tick_up alone in IDLE → no cmd_valid, pending cleared, edit_mode 0.
- tick_enter, tick_left, tick_up, cmd_ready held 1 → edit_mode 1, field_sel 1, one cmd_valid cycle with cmd_op 0, cmd_field 1.
- In EDIT, tick_down with cmd_ready 0 for 10 cycles plus tick_right during ISSUE → cmd_valid held 10 cycles, stable fields; after accept field_sel wraps per right from current value.
- Simultaneous tick_enter and tick_up in EDIT → commit_pulse first, edit_mode 0; up then discarded in IDLE, no command.
- TIMEOUT_CYCLES = 8, enter then idle → abort_pulse exactly 8 cycles after EDIT entry, edit_mode 0, no commit_pulse.
- resetr asserted during ISSUE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/button_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_cmd_scheduler_pkg
// Description : Shared encodings for the button command scheduler: state
//               enum, command op / field codes, button bit positions and a
//               helper that steps the field cursor with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
package button_cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EDIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic       c_op_inc    = 1'b0;
    localparam logic       c_op_dec    = 1'b1;

    localparam logic [1:0] c_field_sec = 2'd0;
    localparam logic [1:0] c_field_min = 2'd1;
    localparam logic [1:0] c_field_hr  = 2'd2;

    // Bit positions in the pending vector; lower index = higher priority.
    localparam int         c_num_btn   = 5;
    localparam int         c_btn_enter = 0;
    localparam int         c_btn_up    = 1;
    localparam int         c_btn_down  = 2;
    localparam int         c_btn_left  = 3;
    localparam int         c_btn_right = 4;

    // Move the cursor one field up (SEC->MIN->HR->SEC) or down
    // (SEC->HR->MIN->SEC). Code 3 is never produced.
    function automatic logic [1:0] field_step(input logic [1:0] f, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (f == c_field_hr || f == 2'd3) ? c_field_sec : f + 2'd1;
        end else begin
            r = (f == c_field_sec || f == 2'd3) ? c_field_hr : f - 2'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_cmd_scheduler_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_prio_arbiter
// Description : Fixed-priority one-hot grant over the pending button bits.
//               Bit 0 (enter) has highest priority, bit 4 (right) lowest.
// Ports       : pending [4:0] in  - latched button requests
//               grant   [4:0] out - one-hot winner, zero when none pending
// Revision    : 1.0 - initial release
// ============================================================================
module button_prio_arbiter
    import button_cmd_scheduler_pkg::*;
(
    input  logic [c_num_btn-1:0] pending,
    output logic [c_num_btn-1:0] grant
);

    // Isolate the lowest set bit: x & -x.
    assign grant = pending & (~pending + {{(c_num_btn-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/button_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : button_cmd_scheduler
// Description : Edit-mode controller between button conditioners and the
//               time-register write port. Latches button ticks, arbitrates
//               them, runs the IDLE/EDIT/ISSUE state machine and issues
//               INC/DEC commands over a valid/ready handshake. An EDIT
//               session with no activity is abandoned after TIMEOUT_CYCLES.
// Ports       : clkr, resetr (sync, active high)
//               tick_enter/up/down/left/right - one-cycle button pulses
//               cmd_ready in; cmd_valid, cmd_op, cmd_field out
//               edit_mode, field_sel, commit_pulse, abort_pulse out
// Revision    : 1.0 - initial release
// ============================================================================
module button_cmd_scheduler
    import button_cmd_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic       clkr,
    input  logic       resetr,
    input  logic       tick_enter,
    input  logic       tick_up,
    input  logic       tick_down,
    input  logic       tick_left,
    input  logic       tick_right,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic       cmd_op,
    output logic [1:0] cmd_field,
    output logic       edit_mode,
    output logic [1:0] field_sel,
    output logic       commit_pulse,
    output logic       abort_pulse
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state, w_state_nxt;
    logic [c_num_btn-1:0]   r_pending, w_ticks, w_grant, w_clear;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [1:0]             r_field, w_field_nxt;
    logic                   r_op, w_op_nxt;
    logic [1:0]             r_cmd_field;
    logic                   r_cmd_valid, r_edit_mode, r_commit, r_abort;
    logic                   w_commit, w_abort;

    assign w_ticks = {tick_right, tick_left, tick_down, tick_up, tick_enter};

    button_prio_arbiter u_arb (
        .pending (r_pending),
        .grant   (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = '0;
        w_cnt_nxt   = r_cnt;
        w_field_nxt = r_field;
        w_op_nxt    = r_op;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only enter means anything here; everything else is dropped.
                w_clear = '1;
                if (w_grant[c_btn_enter]) begin
                    w_state_nxt = S_EDIT;
                    w_field_nxt = c_field_sec;
                    w_cnt_nxt   = '0;
                end
            end
            S_EDIT: begin
                if (|r_pending) begin
                    w_clear   = w_grant;
                    w_cnt_nxt = '0;
                    if (w_grant[c_btn_enter]) begin
                        w_state_nxt = S_IDLE;
                        w_commit    = 1'b1;
                    end else if (w_grant[c_btn_up]) begin
                        w_state_nxt = S_ISSUE;
                        w_op_nxt    = c_op_inc;
                    end else if (w_grant[c_btn_down]) begin
                        w_state_nxt = S_ISSUE;
                        w_op_nxt    = c_op_dec;
                    end else if (w_grant[c_btn_left]) begin
                        w_field_nxt = field_step(r_field, 1'b1);
                    end else begin
                        w_field_nxt = field_step(r_field, 1'b0);
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                    w_clear     = '1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                // Buttons keep latching but are not serviced; counter frozen.
                if (cmd_ready) begin
                    w_state_nxt = S_EDIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkr) begin
        if (resetr) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_cnt       <= '0;
            r_field     <= c_field_sec;
            r_op        <= c_op_inc;
            r_cmd_field <= c_field_sec;
            r_cmd_valid <= 1'b0;
            r_edit_mode <= 1'b0;
            r_commit    <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // A new tick on the same edge as its clear keeps the bit pending.
            r_pending   <= (r_pending & ~w_clear) | w_ticks;
            r_cnt       <= w_cnt_nxt;
            r_field     <= w_field_nxt;
            r_op        <= w_op_nxt;
            if (w_state_nxt == S_ISSUE) begin
                r_cmd_field <= w_field_nxt;
            end
            r_cmd_valid <= (w_state_nxt == S_ISSUE);
            r_edit_mode <= (w_state_nxt != S_IDLE);
            r_commit    <= w_commit;
            r_abort     <= w_abort;
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_op       = r_op;
    assign cmd_field    = r_cmd_field;
    assign edit_mode    = r_edit_mode;
    assign field_sel    = r_field;
    assign commit_pulse = r_commit;
    assign abort_pulse  = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_button_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_cmd_scheduler
// Description : Scoreboard testbench for button_cmd_scheduler. Stimulus pushes
//               expected commands / pulses into a queue; a monitor pops and
//               compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_cmd_scheduler;

    localparam logic [4:0] B_ENTER = 5'b00001;
    localparam logic [4:0] B_UP    = 5'b00010;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b01000;
    localparam logic [4:0] B_RIGHT = 5'b10000;

    localparam logic [1:0] K_CMD    = 2'd0;
    localparam logic [1:0] K_COMMIT = 2'd1;
    localparam logic [1:0] K_ABORT  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       op;
        logic [1:0] field;
    } ev_t;

    logic       clk = 1'b0;
    logic       resetr;
    logic       tick_enter, tick_up, tick_down, tick_left, tick_right;
    logic       cmd_ready;
    logic       cmd_valid, cmd_op, edit_mode, commit_pulse, abort_pulse;
    logic [1:0] cmd_field, field_sel;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    button_cmd_scheduler #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clkr         (clk),
        .resetr       (resetr),
        .tick_enter   (tick_enter),
        .tick_up      (tick_up),
        .tick_down    (tick_down),
        .tick_left    (tick_left),
        .tick_right   (tick_right),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_field    (cmd_field),
        .edit_mode    (edit_mode),
        .field_sel    (field_sel),
        .commit_pulse (commit_pulse),
        .abort_pulse  (abort_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {tick_right, tick_left, tick_down, tick_up, tick_enter} = b;
        step(1);
        {tick_right, tick_left, tick_down, tick_up, tick_enter} = 5'b0;
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic op, input logic [1:0] fld);
        ev_t e;
        e.kind  = kind;
        e.op    = op;
        e.field = fld;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic op, input logic [1:0] fld);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=kind%0d op%0d field%0d required=none",
                     kind, op, fld);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || (kind == K_CMD && (e.op !== op || e.field !== fld))) begin
                errors++;
                $display("FAIL event actual=kind%0d op%0d field%0d required=kind%0d op%0d field%0d",
                         kind, op, fld, e.kind, e.op, e.field);
            end
        end
    endtask

    initial begin
        resetr    = 1'b1;
        cmd_ready = 1'b0;
        {tick_right, tick_left, tick_down, tick_up, tick_enter} = 5'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!resetr) begin
                        if (commit_pulse)           expect_ev(K_COMMIT, 1'b0, 2'd0);
                        if (abort_pulse)            expect_ev(K_ABORT, 1'b0, 2'd0);
                        if (cmd_valid && cmd_ready) expect_ev(K_CMD, cmd_op, cmd_field);
                    end
                end
            end
            begin : stimulus
                // Reset values
                step(2);
                chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
                chk("rst_cmd_op",    32'(cmd_op),    32'd0);
                chk("rst_cmd_field", 32'(cmd_field), 32'd0);
                chk("rst_edit_mode", 32'(edit_mode), 32'd0);
                chk("rst_field_sel", 32'(field_sel), 32'd0);
                chk("rst_pulses",    32'({commit_pulse, abort_pulse}), 32'd0);
                resetr = 1'b0;
                step(1);

                // Up in IDLE is discarded
                press(B_UP);
                step(1);
                chk("idle_up_edit", 32'(edit_mode), 32'd0);
                chk("idle_up_valid", 32'(cmd_valid), 32'd0);
                step(2);

                // Enter, left, up with ready held high
                cmd_ready = 1'b1;
                press(B_ENTER);
                step(1);
                chk("enter_edit_mode", 32'(edit_mode), 32'd1);
                chk("enter_field_sec", 32'(field_sel), 32'd0);
                press(B_LEFT);
                step(1);
                chk("left_field_min", 32'(field_sel), 32'd1);
                push_ev(K_CMD, 1'b0, 2'd1);
                press(B_UP);
                step(1);
                chk("up_valid", 32'(cmd_valid), 32'd1);
                chk("up_op", 32'(cmd_op), 32'd0);
                chk("up_field", 32'(cmd_field), 32'd1);
                step(1);
                chk("up_valid_dropped", 32'(cmd_valid), 32'd0);
                chk("up_back_in_edit", 32'(edit_mode), 32'd1);

                // Down with ready low for 10 cycles; right ticks during ISSUE merge
                cmd_ready = 1'b0;
                press(B_DOWN);
                step(1);
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) begin
                        if (i == 2 || i == 4) tick_right = 1'b1;
                        step(1);
                        tick_right = 1'b0;
                    end
                    chk("hold_valid", 32'(cmd_valid), 32'd1);
                    chk("hold_op_field", 32'({cmd_op, cmd_field}), 32'({1'b1, 2'd1}));
                end
                push_ev(K_CMD, 1'b1, 2'd1);
                cmd_ready = 1'b1;
                step(1);
                chk("down_valid_dropped", 32'(cmd_valid), 32'd0);
                chk("down_field_unchanged", 32'(field_sel), 32'd1);
                step(1);
                chk("right_after_issue", 32'(field_sel), 32'd0);
                step(1);
                chk("right_merged", 32'(field_sel), 32'd0);
                press(B_RIGHT);
                step(1);
                chk("right_wrap_sec_hr", 32'(field_sel), 32'd2);
                press(B_LEFT);
                step(1);
                chk("left_wrap_hr_sec", 32'(field_sel), 32'd0);

                // Enter and up together: commit wins, up discarded in IDLE
                push_ev(K_COMMIT, 1'b0, 2'd0);
                press(B_ENTER | B_UP);
                step(1);
                chk("commit_pulse", 32'(commit_pulse), 32'd1);
                chk("commit_edit_mode", 32'(edit_mode), 32'd0);
                step(1);
                chk("commit_one_cycle", 32'(commit_pulse), 32'd0);
                step(2);
                chk("commit_no_cmd", 32'(cmd_valid), 32'd0);
                chk("commit_still_idle", 32'(edit_mode), 32'd0);

                // Inactivity timeout, 8 cycles after EDIT entry
                push_ev(K_ABORT, 1'b0, 2'd0);
                press(B_ENTER);
                step(1);
                chk("to_edit_entry", 32'(edit_mode), 32'd1);
                step(7);
                chk("to_not_yet", 32'({edit_mode, abort_pulse}), 32'b10);
                step(1);
                chk("to_abort", 32'(abort_pulse), 32'd1);
                chk("to_edit_mode", 32'(edit_mode), 32'd0);
                chk("to_no_commit", 32'(commit_pulse), 32'd0);
                step(1);
                chk("to_abort_one_cycle", 32'(abort_pulse), 32'd0);

                // Reset during ISSUE
                cmd_ready = 1'b0;
                press(B_ENTER);
                step(1);
                press(B_UP);
                step(1);
                chk("pre_reset_valid", 32'(cmd_valid), 32'd1);
                resetr = 1'b1;
                step(1);
                chk("mid_rst_outputs",
                    32'({cmd_valid, cmd_op, cmd_field, edit_mode, field_sel,
                         commit_pulse, abort_pulse}), 32'd0);
                resetr = 1'b0;
                step(2);
                chk("post_rst_idle", 32'({cmd_valid, edit_mode}), 32'd0);

                step(2);
                chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
